// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART receive definitions: FSM state encoding, XINTF command bytes,
// the baud divider computation and the 2-of-3 vote helper.
package uart_rx_frontend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h72;

  // Clocks per oversample tick; truncating division.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable oversample tick divider; tick pulses one clk every DIV clks.
// Shared with the TX side.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Restart zeroes the phase so the first tick lands DIV clks after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver for the XINTF command decoder: synchronises rx, votes
// three mid-bit samples per bit, and reports good bytes or framing errors.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned H   = OVERSAMPLE / 2;

  rx_state_t     state;
  logic [2:0]    sync;
  logic [SW-1:0] s_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          v_lo;
  logic          v_mid;
  logic          upd;
  logic          tick;
  logic          rx_s;
  logic          fall_c;
  logic          restart_c;
  logic          maj_c;
  logic          at_vote_c;
  logic          at_end_c;
  logic [SW-1:0] s_next_c;

  // Two synchroniser flops plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[1:0], rx};
  end

  assign rx_s      = sync[1];
  assign fall_c    = sync[2] & ~sync[1];
  assign restart_c = (state == ST_IDLE) && fall_c;
  assign maj_c     = maj3(v_lo, v_mid, rx_s);
  assign at_vote_c = tick && (s_cnt == SW'(H + 1));
  assign at_end_c  = tick && (s_cnt == SW'(OVERSAMPLE - 1));
  assign s_next_c  = (s_cnt == SW'(OVERSAMPLE - 1)) ? '0 : s_cnt + SW'(1);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart_c),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      s_cnt        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      v_lo         <= 1'b0;
      v_mid        <= 1'b0;
      upd          <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      // rx_valid trails the rx_data update by exactly one clk.
      rx_valid     <= upd;
      upd          <= 1'b0;
      rx_frame_err <= 1'b0;
      if (tick && s_cnt == SW'(H - 1)) v_lo  <= rx_s;
      if (tick && s_cnt == SW'(H))     v_mid <= rx_s;

      case (state)
        ST_IDLE: begin
          if (fall_c) begin
            state   <= ST_START;
            s_cnt   <= '0;
            rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) s_cnt <= s_next_c;
          if (at_vote_c && maj_c) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end else if (at_end_c) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (tick) s_cnt <= s_next_c;
          if (at_vote_c) shreg <= {maj_c, shreg[7:1]};
          if (at_end_c) begin
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          // Decide at the vote so a back-to-back start edge is not missed.
          if (tick) s_cnt <= s_next_c;
          if (at_vote_c) begin
            if (maj_c) begin
              rx_data <= shreg;
              upd     <= 1'b1;
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= ST_BREAK;
              s_cnt        <= '0;
            end
          end
        end
        ST_BREAK: begin
          if (tick) begin
            if (!rx_s) begin
              s_cnt <= '0;
            end else if (s_cnt == SW'(OVERSAMPLE - 1)) begin
              s_cnt   <= '0;
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
